// File: rtl/arb_pkg.sv
// Shared sizes and state encoding for the eight-way round-robin grant encoder.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Circular first-set search over eight requests, starting at ptr.
// Combinational (0 cycles); no flow control.
// Rotate so ptr lands at bit 0, fixed-priority pick, then add ptr back.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = IDX_W'(j);
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/rr_grant_encoder8.sv
// Round-robin arbiter for eight requesters; offers the winner as a binary index and holds ownership until done or timeout.
// Latency: req to gnt_valid 1 cycle; done to next gnt_valid 2 cycles.
// Backpressure: the offer is frozen until gnt_ready, or withdrawn if the chosen request drops.
module rr_grant_encoder8
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_valid,
    input  logic               gnt_ready,
    output logic [IDX_W-1:0]   gnt_idx,
    input  logic               done,
    output logic               busy,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_d;
    logic             vld_d, busy_d, timeout_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             timeout_hit;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Accept beats withdrawal; done beats timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = OFFER;
            OFFER: begin
                if (gnt_ready)          state_d = BUSY;
                else if (!req[gnt_idx]) state_d = IDLE;
            end
            BUSY:    if (done || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        idx_d     = gnt_idx;
        vld_d     = gnt_valid;
        busy_d    = busy;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d = pick_idx;
                    vld_d = 1'b1;
                end
            end
            OFFER: begin
                if (gnt_ready) begin
                    ptr_d  = gnt_idx + IDX_W'(1);
                    vld_d  = 1'b0;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                end else if (!req[gnt_idx]) begin
                    vld_d = 1'b0;
                end
            end
            BUSY: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    busy_d = 1'b0;
                end else if (timeout_hit) begin
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                vld_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= vld_d;
            busy      <= busy_d;
            timeout   <= timeout_d;
        end
    end

endmodule
